tron_stepper: RTL and testbench
===============================

# tron_stepper

Consumes the slow square wave from the game-speed scaler and turns each of its rising edges into one grid step of a Tron light-cycle. Synchronises and edge-detects `clock_hz` in the 50 MHz domain, applies the player's latched direction request, and advances an X/Y grid position. Each new position is offered to the downstream trail/collision writer over a valid/ready handshake.

## Interface
- `GRID_W`, 80: grid columns; X range 0..GRID_W-1
- `GRID_H`, 60: grid rows; Y range 0..GRID_H-1
- `START_X`, 40: X after reset
- `START_Y`, 30: Y after reset
- `START_DIR`, 1 (RIGHT): direction after reset
- `clock_50mhz`  in  1  system clock; everything is in this domain
- `reset_n`  in  1  asynchronous, active-low reset
- `clock_hz`  in  1  slow square wave from the scaler; asynchronous to this logic, so it is treated as such
- `run`  in  1  high = game running; low = ticks ignored
- `dir_req`  in  2  requested direction: 0 UP, 1 RIGHT, 2 DOWN, 3 LEFT
- `dir_req_valid`  in  1  one-cycle strobe qualifying `dir_req`
- `step_ready`  in  1  downstream accepts the current step
- `step_valid`  out  1  `pos_x`/`pos_y`/`dir` hold a new step
- `pos_x`  out  $clog2(GRID_W)  current X
- `pos_y`  out  $clog2(GRID_H)  current Y
- `dir`  out  2  direction used for the current position
- `overrun`  out  1  sticky; a tick arrived while a step was still pending
- `crashed`  out  1  sticky; the cycle hit a grid edge (only without wrap)

## Operation
- Reset values: `pos_x`=START_X, `pos_y`=START_Y, `dir`=START_DIR, pending direction=START_DIR, `step_valid`=0, `overrun`=0, `crashed`=0, FSM=IDLE, sync flops=0.
- Tick generation:
  - `clock_hz` passes through a 2-flop synchroniser and a 1-flop edge register.
  - `tick` is a one-cycle pulse on each synchronised rising edge. Falling edges produce no tick.
- Direction requests:
  - On `dir_req_valid`, `dir_req` is latched into the pending direction unless it is the reverse of the current `dir` (XOR of the two equals 2). A reversal is dropped silently.
  - With several requests between ticks, the last accepted one wins. Reversal is checked against `dir`, not against the pending value.
- FSM states:
  - IDLE: leave when `run`=1, go to WAIT.
  - WAIT: on `tick`, go to STEP. If `run`=0, go back to IDLE.
  - STEP: set `dir` to the pending direction, compute the next position, assert `step_valid`, go to PEND.
  - PEND: on `step_valid && step_ready`, clear `step_valid` and go to WAIT. A `tick` seen in PEND sets `overrun`, and that tick is discarded. `run` dropping in PEND does not abort the handshake.
  - CRASH: terminal; only `reset_n` leaves it.
- Arithmetic:
  - UP: y-1. DOWN: y+1. RIGHT: x+1. LEFT: x-1.
  - Edge cases: x=0 moving LEFT, x=GRID_W-1 moving RIGHT, y=0 moving UP, y=GRID_H-1 moving DOWN. Their handling is set by the configuration macro.
- Outputs stay stable while `step_valid`=1.
- `reset_n` asserted mid-operation clears everything to reset values immediately, including a pending step. `step_valid` drops without a handshake.

## Timing
- Latency from a `clock_hz` rising edge to `tick` is 3 clocks. Latency from `tick` to `step_valid` is 2 clocks (STEP, then PEND).
- Step period = one `clock_hz` period = 2·(reset_cnt+1) clocks.
- `step_ready` may be held high permanently. The step then completes in the first PEND cycle.
- A `dir_req_valid` in the same cycle as STEP is not applied to this step. It applies to the next one.

## Configuration
- `TRON_STEPPER_WRAP_EN` defined: edge moves wrap. X goes GRID_W-1↔0 and Y goes GRID_H-1↔0. `crashed` stays 0.
- `TRON_STEPPER_WRAP_EN` undefined: an edge move leaves the position unchanged, sets `crashed`, and sends the FSM to CRASH. No `step_valid` is issued for that move.

## Structure
- Shared package `tron_pkg` holds:
  - the direction encoding constants DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT
  - the state typedef `stepper_state_t` (IDLE, WAIT, STEP, PEND, CRASH)
  - the default grid dimensions
- One sub-module, `tick_sync`: 2-flop synchroniser plus rising-edge detector, output `tick`.

## Test plan
- Reset, `run`=1, `step_ready`=1, one `clock_hz` rise -> `step_valid` 5 clocks after the edge, pos (41,30), `dir`=1.
- Current RIGHT, request LEFT(3) then DOWN(2) before the tick -> LEFT dropped; step goes to (x, y+1) with `dir`=2.
- `step_ready`=0 across two `clock_hz` rises -> `overrun`=1. The position advances only once, and stays stable until ready.
- With WRAP_EN, x=79 moving RIGHT -> pos_x=0. Without WRAP_EN -> `crashed`=1, no `step_valid`, further ticks ignored.
- `run`=0 with `clock_hz` toggling -> no steps. Raise `run` -> the next rise steps normally.
- Assert `reset_n` while `step_valid`=1 -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/tron_pkg.sv
// Shared types and constants for the Tron light-cycle stepper.
// Direction encoding, FSM state type and default grid geometry.
package tron_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam int GRID_W_DEF  = 80;
  localparam int GRID_H_DEF  = 60;
  localparam int START_X_DEF = 40;
  localparam int START_Y_DEF = 30;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    STEP,
    PEND,
    CRASH
  } stepper_state_t;

  // Opposite directions differ only in bit 1.
  function automatic logic is_reverse(
    input logic [1:0] a,
    input logic [1:0] b
  );
    return (a ^ b) == 2'd2;
  endfunction

endpackage

// File: rtl/tron_stepper_tick_sync.sv
// Synchroniser and rising-edge detector for the slow game clock.
// Emits a registered one-cycle tick per synchronised rising edge.
module tick_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic tick_o
);

  logic s1_q, s2_q, s3_q, tick_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      tick_q <= s2_q & ~s3_q;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/tron_stepper.sv
// Tron light-cycle grid stepper: one step per game-clock rising edge.
// Define TRON_STEPPER_WRAP_EN to wrap at grid edges instead of crashing.
module tron_stepper
  import tron_pkg::*;
#(
  parameter int         GRID_W    = GRID_W_DEF,
  parameter int         GRID_H    = GRID_H_DEF,
  parameter int         START_X   = START_X_DEF,
  parameter int         START_Y   = START_Y_DEF,
  parameter logic [1:0] START_DIR = DIR_RIGHT
) (
  input  logic                      clock_50mhz,
  input  logic                      reset_n,
  input  logic                      clock_hz,
  input  logic                      run,
  input  logic [1:0]                dir_req,
  input  logic                      dir_req_valid,
  input  logic                      step_ready,
  output logic                      step_valid,
  output logic [$clog2(GRID_W)-1:0] pos_x,
  output logic [$clog2(GRID_H)-1:0] pos_y,
  output logic [1:0]                dir,
  output logic                      overrun,
  output logic                      crashed
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam logic [XW-1:0] XMAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(GRID_H - 1);

  stepper_state_t state_q, state_d;

  logic [XW-1:0] x_q, x_nxt;
  logic [YW-1:0] y_q, y_nxt;
  logic [1:0]    dir_q, pend_q;
  logic          valid_q, ovr_q, crash_q;
  logic          tick, edge_hit, crash_go;
  logic          do_step, do_crash, do_ack, ovr_set;

  tick_sync u_tick (
    .clk_i   (clock_50mhz),
    .rst_ni  (reset_n),
    .async_i (clock_hz),
    .tick_o  (tick)
  );

  always_comb begin
    x_nxt    = x_q;
    y_nxt    = y_q;
    edge_hit = 1'b0;
    case (pend_q)
      DIR_UP: begin
        edge_hit = (y_q == '0);
        y_nxt    = edge_hit ? YMAX : y_q - 1'b1;
      end
      DIR_RIGHT: begin
        edge_hit = (x_q == XMAX);
        x_nxt    = edge_hit ? '0 : x_q + 1'b1;
      end
      DIR_DOWN: begin
        edge_hit = (y_q == YMAX);
        y_nxt    = edge_hit ? '0 : y_q + 1'b1;
      end
      default: begin
        edge_hit = (x_q == '0);
        x_nxt    = edge_hit ? XMAX : x_q - 1'b1;
      end
    endcase
  end

`ifdef TRON_STEPPER_WRAP_EN
  assign crash_go = 1'b0;
`else
  assign crash_go = edge_hit;
`endif

  always_ff @(posedge clock_50mhz or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (run) state_d = WAIT;
      WAIT: begin
        if (tick)      state_d = STEP;
        else if (!run) state_d = IDLE;
      end
      STEP:  state_d = crash_go ? CRASH : PEND;
      PEND:  if (valid_q && step_ready) state_d = WAIT;
      CRASH: state_d = CRASH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    do_step  = (state_q == STEP) && !crash_go;
    do_crash = (state_q == STEP) &&  crash_go;
    do_ack   = (state_q == PEND) && valid_q && step_ready;
    ovr_set  = (state_q == PEND) && tick;
  end

  always_ff @(posedge clock_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= XW'(START_X);
      y_q     <= YW'(START_Y);
      dir_q   <= START_DIR;
      pend_q  <= START_DIR;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      crash_q <= 1'b0;
    end else begin
      if (dir_req_valid && !is_reverse(dir_req, dir_q))
        pend_q <= dir_req;
      if (do_step) begin
        x_q     <= x_nxt;
        y_q     <= y_nxt;
        dir_q   <= pend_q;
        valid_q <= 1'b1;
      end
      if (do_ack)   valid_q <= 1'b0;
      if (do_crash) crash_q <= 1'b1;
      if (ovr_set)  ovr_q   <= 1'b1;
    end
  end

  assign step_valid = valid_q;
  assign pos_x      = x_q;
  assign pos_y      = y_q;
  assign dir        = dir_q;
  assign overrun    = ovr_q;
  assign crashed    = crash_q;

endmodule

// File: tb/tb_tron_stepper.sv
// Directed self-checking bench for tron_stepper.
// Honours TRON_STEPPER_WRAP_EN for the grid-edge case.
module tb_tron_stepper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hz;
  logic       run;
  logic [1:0] dreq;
  logic       dreq_v;
  logic       rdy;
  logic       sv;
  logic [6:0] px;
  logic [5:0] py;
  logic [1:0] dr;
  logic       ovr;
  logic       crs;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tron_stepper dut (
    .clock_50mhz   (clk),
    .reset_n       (rst_n),
    .clock_hz      (hz),
    .run           (run),
    .dir_req       (dreq),
    .dir_req_valid (dreq_v),
    .step_ready    (rdy),
    .step_valid    (sv),
    .pos_x         (px),
    .pos_y         (py),
    .dir           (dr),
    .overrun       (ovr),
    .crashed       (crs)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_step(input string tag);
    bit got = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (sv) begin
        got = 1;
        break;
      end
    end
    if (!got) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic hz_fall();
    hz = 1'b0;
    cyc(6);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    bit seen;
    rst_n  = 1'b1;
    hz     = 1'b0;
    run    = 1'b0;
    dreq   = 2'd0;
    dreq_v = 1'b0;
    rdy    = 1'b0;
    #2;
    do_reset();

    chk("rst_x", px, 40);
    chk("rst_y", py, 30);
    chk("rst_dir", dr, 1);
    chk("rst_valid", sv, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_crash", crs, 0);

    // First step: valid exactly 5 clocks after the rise.
    run = 1'b1;
    rdy = 1'b1;
    cyc(3);
    hz = 1'b1;
    cyc(4);
    chk("lat_early", sv, 0);
    cyc(1);
    chk("lat_valid", sv, 1);
    chk("s1_x", px, 41);
    chk("s1_y", py, 30);
    chk("s1_dir", dr, 1);
    cyc(1);
    chk("s1_ack", sv, 0);
    hz_fall();

    // Reversal dropped, later request wins.
    dreq   = 2'd3;
    dreq_v = 1'b1;
    cyc(1);
    dreq   = 2'd2;
    cyc(1);
    dreq_v = 1'b0;
    hz = 1'b1;
    wait_step("s2");
    chk("s2_x", px, 41);
    chk("s2_y", py, 31);
    chk("s2_dir", dr, 2);
    hz_fall();

    // Back-pressure across two rises.
    rdy = 1'b0;
    hz  = 1'b1;
    wait_step("s3");
    chk("s3_y", py, 32);
    hz_fall();
    hz = 1'b1;
    cyc(8);
    chk("ovr_set", ovr, 1);
    chk("ovr_valid", sv, 1);
    chk("ovr_x", px, 41);
    chk("ovr_y", py, 32);
    hz_fall();
    rdy = 1'b1;
    cyc(1);
    chk("ovr_ack", sv, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (sv) seen = 1;
    end
    chk("ovr_drop", seen, 0);
    chk("ovr_y2", py, 32);

    // Ticks ignored while not running.
    run  = 1'b0;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      hz = 1'b1;
      for (int i = 0; i < 6; i++) begin
        cyc(1);
        if (sv) seen = 1;
      end
      hz = 1'b0;
      for (int i = 0; i < 6; i++) begin
        cyc(1);
        if (sv) seen = 1;
      end
    end
    chk("norun_valid", seen, 0);
    chk("norun_y", py, 32);
    run = 1'b1;
    cyc(2);
    hz = 1'b1;
    wait_step("s4");
    chk("s4_y", py, 33);
    hz_fall();

    // Reset while a step is pending.
    rdy = 1'b0;
    hz  = 1'b1;
    wait_step("s5");
    chk("s5_y", py, 34);
    hz = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", sv, 0);
    chk("arst_x", px, 40);
    chk("arst_y", py, 30);
    chk("arst_dir", dr, 1);
    chk("arst_ovr", ovr, 0);
    #8;
    rst_n = 1'b1;
    cyc(3);

    // Run to the right edge.
    rdy = 1'b1;
    for (int k = 0; k < 39; k++) begin
      hz = 1'b1;
      wait_step("walk");
      hz_fall();
    end
    chk("edge_x", px, 79);
    chk("edge_y", py, 30);
    hz   = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (sv) seen = 1;
    end
    hz_fall();
`ifdef TRON_STEPPER_WRAP_EN
    chk("wrap_valid", seen, 1);
    chk("wrap_x", px, 0);
    chk("wrap_crash", crs, 0);
`else
    chk("crash_valid", seen, 0);
    chk("crash_x", px, 79);
    chk("crash_flag", crs, 1);
    hz   = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (sv) seen = 1;
    end
    hz_fall();
    chk("crash_hold", seen, 0);
    chk("crash_x2", px, 79);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
